pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage pipeline.
//  - Drives the enable/flush of the IF/ID, ID/EX and EX/MEM registers, PC enable and PC redirect.
//  - Generates ALU operand forwarding selects and handles load-use stalls.
//  - Freezes the pipe while a MEM-stage data access waits for memory acknowledge.
// PARAMETERS
//  REG_AW      5     register address width
//  LU_STALLS   1     bubbles inserted per load-use hazard (1..7)
//  MEM_TIMEOUT 255   wait cycles before mem_err is raised (8-bit, >=1)
// PORTS
//  clk           in  1   clock, all state updates on posedge
//  rst_n         in  1   asynchronous active-low reset
//  id_rs1,id_rs2 in  REG_AW  source regs of instruction in ID
//  id_use_rs1/2  in  1   ID instruction reads rs1/rs2
//  ex_rs1,ex_rs2 in  REG_AW  source regs of instruction in EX
//  id_ex_rd      in  REG_AW  dest reg in ID/EX
//  id_ex_mem_read in 1   ID/EX instruction is a load
//  ex_mem_rd     in  REG_AW  dest reg in EX/MEM
//  ex_mem_regwrite in 1  EX/MEM writes a register
//  ex_mem_mem_rd/ex_mem_mem_wr in 1  MEM-stage load/store
//  ex_mem_redirect in 1  taken jump/branch resolved in MEM (jump & Zero qualified)
//  mem_wb_rd     in  REG_AW  dest reg in MEM/WB
//  mem_wb_regwrite in 1  MEM/WB writes a register
//  mem_ack       in  1   data memory completes the current access
//  mem_req       out 1   data memory access request
//  pc_en, if_id_en, id_ex_en, ex_mem_en out 1  stage-register load enables
//  if_id_flush, id_ex_flush, ex_mem_flush out 1  load a bubble (all controls 0)
//  pc_redirect   out 1   PC takes the branch target this cycle
//  fwd_a, fwd_b  out 2   00 regfile, 10 EX/MEM ALU result, 01 MEM/WB data
//  stall_cnt     out 32  saturating count of cycles with pc_en=0
//  mem_err       out 1   sticky: memory wait exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//  - State goes to RUN; internal counters clear; stall_cnt=0, mem_err=0.
//  - While held low: all enables=0, all flushes=1, mem_req=0, pc_redirect=0, fwd=00.
//  FSM states: RUN, LSTALL, MEMWAIT. Outputs are combinational from state and inputs.
//  mem_req = ex_mem_mem_rd | ex_mem_mem_wr in RUN and MEMWAIT, else 0.
//  Priority each cycle: memory wait > redirect > load-use > normal flow.
//  Memory wait:
//  - Condition: mem_req=1 and mem_ack=0.
//  - All enables 0, no flushes. Go to or stay in MEMWAIT; the wait counter increments.
//  - When the counter reaches MEM_TIMEOUT, mem_err sets and the pipe keeps waiting.
//  - On the mem_ack cycle: all enables 1, counter clears, next state RUN.
//    Zero-wait access (mem_ack in the request cycle) never leaves RUN.
//  Redirect (ex_mem_redirect=1, no memory wait):
//  - pc_redirect=1, pc_en=1, if_id_flush=id_ex_flush=ex_mem_flush=1.
//  - Next state RUN. Aborts LSTALL and clears its counter.
//  Load-use: id_ex_mem_read & id_ex_rd!=0 & (rs1 match & id_use_rs1 | rs2 match & id_use_rs2).
//  - pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=1.
//  - When LU_STALLS>1: enter LSTALL and hold the same outputs for LU_STALLS-1 further cycles, then RUN.
//  - A hazard arising in LSTALL does not re-arm the stall.
//  Normal flow: all enables 1, no flushes, pc_redirect=0.
//  Forwarding (fwd_a on ex_rs1, fwd_b on ex_rs2; evaluated in every state):
//  - 10 if ex_mem_regwrite & ex_mem_rd!=0 & ex_mem_rd==src.
//  - Else 01 if mem_wb_regwrite & mem_wb_rd!=0 & mem_wb_rd==src.
//  - Else 00. EX/MEM wins over MEM/WB.
//  stall_cnt increments when pc_en=0 and rst_n=1, saturating at 32'hFFFFFFFF.
// TESTING
//  1) Load x5 in ID/EX, ID reads x5 (id_use_rs1=1) -> 1 cycle pc_en=0,id_ex_flush=1; stall_cnt=1.
//  2) ex_mem_rd=x3 regwrite, mem_wb_rd=x3 regwrite, ex_rs1=x3 -> fwd_a=10; ex_rs1=x0 -> fwd_a=00.
//  3) Store in MEM, mem_ack after 4 cycles -> 4 cycles all enables 0, mem_req=1; ack cycle enables 1.
//  4) ex_mem_redirect=1 while load-use present -> pc_redirect=1, three flushes, pc_en=1, no stall.
//  5) MEM_TIMEOUT=3, ack never -> mem_err=1 after 3 wait cycles; stays 1 until reset.
//  6) rst_n low mid-MEMWAIT -> enables 0, flushes 1 immediately; after release state RUN, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline.
// It drives the stage-register enables and flushes, the PC enable and the PC redirect.
// It also generates the ALU operand forwarding selects, inserts load-use bubbles,
// and freezes the pipe while a MEM-stage access waits for memory acknowledge.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int LU_STALLS   = 1,    // bubbles per load-use hazard, 1..7
    parameter int MEM_TIMEOUT = 255   // wait cycles before mem_err, 1..255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic              ex_mem_mem_rd,
    input  logic              ex_mem_mem_wr,
    input  logic              ex_mem_redirect,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              pc_redirect,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [31:0]       stall_cnt,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LSTALL  = 2'd1,
        MEMWAIT = 2'd2
    } state_e;

    // These are the extra LSTALL cycles that follow the first bubble.
    localparam logic [2:0] LU_EXTRA = 3'(LU_STALLS - 1);
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  lu_cnt_q, lu_cnt_d;     // LSTALL cycles remaining, including the current one
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic        load_use;
    logic        mem_wait;

    // Selects the forwarding source for one EX operand. The EX/MEM stage wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] xm_rd,
        input logic              xm_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic              mw_we
    );
        if (xm_we && (xm_rd != '0) && (xm_rd == src)) begin
            return 2'b10;
        end else if (mw_we && (mw_rd != '0) && (mw_rd == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // Computes the next state and the pipeline controls from the current state and the inputs.
    // NOTE: every output and every *_d signal gets a default at the top, so no path can infer a latch.
    always_comb begin
        state_d      = RUN;
        wait_cnt_d   = '0;
        lu_cnt_d     = '0;
        mem_err_d    = mem_err_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;

        mem_req  = (state_q != LSTALL) && (ex_mem_mem_rd || ex_mem_mem_wr);
        mem_wait = mem_req && !mem_ack;
        load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                   (((id_rs1 == id_ex_rd) && id_use_rs1) ||
                    ((id_rs2 == id_ex_rd) && id_use_rs2));

        if (mem_wait) begin
            // Freeze every stage. The pipe keeps waiting after a timeout, and mem_err only flags it.
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            state_d    = MEMWAIT;
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d >= TIMEOUT) begin
                mem_err_d = 1'b1;
            end
        end else if (ex_mem_redirect) begin
            // A taken branch squashes the three younger instructions and aborts any load-use stall.
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (state_q == LSTALL) begin
            // A hazard seen in this state does not re-arm the stall; the counter only runs down.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (lu_cnt_q > 3'd1) begin
                state_d  = LSTALL;
                lu_cnt_d = lu_cnt_q - 3'd1;
            end
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (LU_STALLS > 1) begin
                state_d  = LSTALL;
                lu_cnt_d = LU_EXTRA;
            end
        end

        fwd_a = fwd_sel(ex_rs1, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);
        fwd_b = fwd_sel(ex_rs2, ex_mem_rd, ex_mem_regwrite, mem_wb_rd, mem_wb_regwrite);

        stall_cnt_d = (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                 : stall_cnt_q;

        // While reset is asserted, the pipe is held fully bubbled, even before the first clock edge.
        if (!rst_n) begin
            mem_req      = 1'b0;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pc_redirect  = 1'b0;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
        end
    end

    // Holds the state register and the counters. Reset is asynchronous.
    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            lu_cnt_q    <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign mem_err   = mem_err_q;

endmodule
